round_controller: RTL and testbench

//  Game sequencer feeding screen_drawer. Runs the doors game rounds:
//   - picks two distinct correct doors from a free-running LFSR
//   - tracks both players' door positions and counts down the round timer
//   - raises time_up for the door reveal, then charges lives and decides game over
//  All outputs are registered and connect directly to the screen_drawer inputs of the same names.

---
 rtl/round_controller.sv | 196 +++++++++++++++++++
 tb/tb_round_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// round_controller
//   Game sequencer for the doors game. Each round it picks two distinct
//   correct doors from a free-running LFSR. It tracks both players' door
//   positions and counts the round timer down to zero. It then shows the
//   doors open (time_up), charges a life to every player standing on a
//   wrong door, and either starts the next round or ends the game.
//   All outputs are registered and feed screen_drawer directly.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   start               1-cycle pulse, begins a game from IDLE or OVER
//   p1_left/p1_right    1-cycle move pulses for player 1
//   p2_left/p2_right    1-cycle move pulses for player 2
//   correct_door_1/2    the two correct doors of the current round (distinct)
//   p1_lives/p2_lives   remaining lives
//   player_1_pos/2_pos  door index of each player
//   resume              1-cycle pulse on the first cycle of a new round
//   time_up             doors shown open (REVEAL and OVER)
//   seconds_left        round countdown
//   game_over           high in OVER
//   winner              01 P1, 10 P2, 11 draw while in OVER; 00 otherwise
module round_controller #(
   parameter int unsigned CLK_HZ         = 25_000_000,
   parameter int unsigned ROUND_SECONDS  = 10,
   parameter int unsigned REVEAL_SECONDS = 3,
   parameter int unsigned LIVES_INIT     = 3,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       p1_left,
   input  logic       p1_right,
   input  logic       p2_left,
   input  logic       p2_right,
   output logic [1:0] correct_door_1,
   output logic [1:0] correct_door_2,
   output logic [1:0] p1_lives,
   output logic [1:0] p2_lives,
   output logic [1:0] player_1_pos,
   output logic [1:0] player_2_pos,
   output logic       resume,
   output logic       time_up,
   output logic [3:0] seconds_left,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int unsigned TW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
   localparam logic [3:0] ROUND_LOAD   = 4'(ROUND_SECONDS);
   localparam logic [3:0] REVEAL_LAST  = 4'(REVEAL_SECONDS - 1);
   localparam logic [1:0] LIVES_LOAD   = 2'(LIVES_INIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_PLAY,
      S_REVEAL,
      S_OVER
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    lfsr, lfsr_shift;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    reveal_cnt;
   logic [1:0]    door_2_pick;
   logic [1:0]    p1_moved, p2_moved;
   logic          p1_hit, p2_hit;
   logic          entering_timed;

   // One door step. Both directions at once cancel. Walls at 0 and 3 hold.
   function automatic logic [1:0] step_pos(input logic [1:0] pos,
                                           input logic left,
                                           input logic right);
      logic [1:0] r;
      r = pos;
      if (left && !right && pos != 2'd0)
         r = pos - 2'd1;
      else if (right && !left && pos != 2'd3)
         r = pos + 2'd1;
      return r;
   endfunction

   // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
   assign lfsr_shift = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign tick       = (tick_cnt == TICK_LAST);

   // Second door is forced distinct by bumping past the first one.
   assign door_2_pick = (lfsr[3:2] == lfsr[1:0]) ? (lfsr[1:0] + 2'd1) : lfsr[3:2];

   // Moves are only live during PLAY. The post-move position is also what
   // the life check uses, so a pulse on the final edge still counts.
   assign p1_moved = (state == S_PLAY) ? step_pos(player_1_pos, p1_left, p1_right)
                                       : player_1_pos;
   assign p2_moved = (state == S_PLAY) ? step_pos(player_2_pos, p2_left, p2_right)
                                       : player_2_pos;
   assign p1_hit   = (p1_moved == correct_door_1) || (p1_moved == correct_door_2);
   assign p2_hit   = (p2_moved == correct_door_1) || (p2_moved == correct_door_2);

   // Timed states restart the second counter so a full second elapses
   // before their first tick.
   assign entering_timed = (state_nxt != state) &&
                           ((state_nxt == S_PLAY) || (state_nxt == S_REVEAL));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_PICK;
         S_PICK:   state_nxt = S_PLAY;
         S_PLAY:   if (tick && seconds_left == 4'd1) state_nxt = S_REVEAL;
         S_REVEAL: begin
            if (tick && reveal_cnt == REVEAL_LAST)
               state_nxt = (p1_lives == 2'd0 || p2_lives == 2'd0) ? S_OVER : S_PICK;
         end
         S_OVER:   if (start) state_nxt = S_PICK;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr           <= LFSR_SEED;
         tick_cnt       <= '0;
         reveal_cnt     <= 4'd0;
         correct_door_1 <= 2'd0;
         correct_door_2 <= 2'd1;
         p1_lives       <= LIVES_LOAD;
         p2_lives       <= LIVES_LOAD;
         player_1_pos   <= 2'd0;
         player_2_pos   <= 2'd3;
         resume         <= 1'b0;
         time_up        <= 1'b0;
         seconds_left   <= 4'd0;
         game_over      <= 1'b0;
         winner         <= 2'd0;
      end else begin
         // The all-zero state would lock the LFSR; reseed defensively.
         lfsr <= (lfsr_shift == 8'h00) ? LFSR_SEED : lfsr_shift;

         if (entering_timed || tick)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + TW'(1);

         resume    <= (state == S_PICK);
         time_up   <= (state_nxt == S_REVEAL) || (state_nxt == S_OVER);
         game_over <= (state_nxt == S_OVER);

         case (state)
            S_PICK: begin
               correct_door_1 <= lfsr[1:0];
               correct_door_2 <= door_2_pick;
               seconds_left   <= ROUND_LOAD;
            end
            S_PLAY: begin
               player_1_pos <= p1_moved;
               player_2_pos <= p2_moved;
               if (tick)
                  seconds_left <= seconds_left - 4'd1;
               if (state_nxt == S_REVEAL) begin
                  reveal_cnt <= 4'd0;
                  if (!p1_hit && p1_lives != 2'd0) p1_lives <= p1_lives - 2'd1;
                  if (!p2_hit && p2_lives != 2'd0) p2_lives <= p2_lives - 2'd1;
               end
            end
            S_REVEAL: begin
               if (tick)
                  reveal_cnt <= reveal_cnt + 4'd1;
               // Bit 1 flags P1 out (P2 wins), bit 0 flags P2 out (P1 wins).
               if (state_nxt == S_OVER)
                  winner <= {p1_lives == 2'd0, p2_lives == 2'd0};
            end
            S_OVER: begin
               if (start) begin
                  p1_lives     <= LIVES_LOAD;
                  p2_lives     <= LIVES_LOAD;
                  player_1_pos <= 2'd0;
                  player_2_pos <= 2'd3;
                  winner       <= 2'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller. A cycle-level reference model tracks the game
// by counting clock cycles left in each phase. Every cycle, all outputs
// are compared against it. Directed phases cover reset, moves, door wrap,
// a full three-round game and an async reset during play. A randomized run
// follows.
module tb_round_controller;

   localparam int CLK_HZ = 10;
   localparam int ROUND  = 3;
   localparam int REVEAL = 2;
   localparam int LIVES  = 3;

   localparam int PH_IDLE = 0, PH_PICK = 1, PH_PLAY = 2, PH_REVEAL = 3, PH_OVER = 4;

   localparam logic [31:0] RESET_VEC = {11'b0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd3,
                                        1'b0, 1'b0, 4'd0, 1'b0, 2'd0};

   logic       clk, reset_n, start;
   logic       p1_left, p1_right, p2_left, p2_right;
   logic [1:0] correct_door_1, correct_door_2, p1_lives, p2_lives;
   logic [1:0] player_1_pos, player_2_pos, winner;
   logic       resume, time_up, game_over;
   logic [3:0] seconds_left;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int         m_ph, m_left, m_l1, m_l2, m_p1, m_p2;
   logic [7:0] m_lfsr;
   logic [1:0] m_d1, m_d2, m_win;
   logic [3:0] m_sec;
   logic       m_res;

   round_controller #(
      .CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND), .REVEAL_SECONDS(REVEAL),
      .LIVES_INIT(LIVES), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .reset(reset_n), .start(start),
      .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
      .correct_door_1(correct_door_1), .correct_door_2(correct_door_2),
      .p1_lives(p1_lives), .p2_lives(p2_lives),
      .player_1_pos(player_1_pos), .player_2_pos(player_2_pos),
      .resume(resume), .time_up(time_up), .seconds_left(seconds_left),
      .game_over(game_over), .winner(winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {11'b0, correct_door_1, correct_door_2, p1_lives, p2_lives,
              player_1_pos, player_2_pos, resume, time_up, seconds_left, game_over, winner};
   endfunction

   function automatic logic [31:0] mdl_vec();
      return {11'b0, m_d1, m_d2, 2'(m_l1), 2'(m_l2), 2'(m_p1), 2'(m_p2), m_res,
              (m_ph == PH_REVEAL || m_ph == PH_OVER), m_sec, (m_ph == PH_OVER), m_win};
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int clamp_move(input int pos, input logic l, input logic r);
      int p;
      p = pos + int'(r) - int'(l);
      if (p < 0) p = 0;
      if (p > 3) p = 3;
      return p;
   endfunction

   task automatic model_reset();
      m_ph = PH_IDLE; m_left = 0; m_l1 = LIVES; m_l2 = LIVES; m_p1 = 0; m_p2 = 3;
      m_lfsr = 8'hA5; m_d1 = 2'd0; m_d2 = 2'd1; m_win = 2'd0; m_sec = 4'd0; m_res = 1'b0;
   endtask

   task automatic model_step(input logic st, input logic l1, input logic r1,
                             input logic l2, input logic r2);
      logic [7:0] cur;
      int d1, d2;
      cur    = m_lfsr;
      m_lfsr = lfsr_next(cur);
      m_res  = (m_ph == PH_PICK);
      case (m_ph)
         PH_IDLE: if (st) m_ph = PH_PICK;
         PH_PICK: begin
            d1 = int'(cur) % 4;
            d2 = (int'(cur) / 4) % 4;
            if (d2 == d1) d2 = (d1 + 1) % 4;
            m_d1 = 2'(d1); m_d2 = 2'(d2);
            m_sec = 4'(ROUND); m_left = ROUND * CLK_HZ; m_ph = PH_PLAY;
         end
         PH_PLAY: begin
            m_p1 = clamp_move(m_p1, l1, r1);
            m_p2 = clamp_move(m_p2, l2, r2);
            m_left--;
            m_sec = 4'((m_left + CLK_HZ - 1) / CLK_HZ);
            if (m_left == 0) begin
               if (m_p1 != int'(m_d1) && m_p1 != int'(m_d2) && m_l1 > 0) m_l1--;
               if (m_p2 != int'(m_d1) && m_p2 != int'(m_d2) && m_l2 > 0) m_l2--;
               m_ph = PH_REVEAL; m_left = REVEAL * CLK_HZ;
            end
         end
         PH_REVEAL: begin
            m_left--;
            if (m_left == 0) begin
               if (m_l1 == 0 || m_l2 == 0) begin
                  m_ph = PH_OVER;
                  if (m_l1 > 0)      m_win = 2'b01;
                  else if (m_l2 > 0) m_win = 2'b10;
                  else               m_win = 2'b11;
               end else
                  m_ph = PH_PICK;
            end
         end
         PH_OVER: if (st) begin
            m_l1 = LIVES; m_l2 = LIVES; m_p1 = 0; m_p2 = 3; m_win = 2'b00; m_ph = PH_PICK;
         end
         default: ;
      endcase
   endtask

   task automatic cycle(input logic st, input logic l1, input logic r1,
                        input logic l2, input logic r2);
      start = st; p1_left = l1; p1_right = r1; p2_left = l2; p2_right = r2;
      @(posedge clk);
      if (reset_n) model_step(st, l1, r1, l2, r2);
      #1 chk("cycle", dut_vec(), mdl_vec());
   endtask

   // Steer P1 onto the first correct door and P2 onto a wrong one until the reveal.
   task automatic play_round(input int exp_p2_lives, input logic count_reveal);
      int n, t2, cnt;
      logic a, b, c, d;
      n = 0;
      while (m_ph != PH_REVEAL && n < 200) begin
         t2 = 0;
         for (int k = 3; k >= 0; k--)
            if (k != int'(m_d1) && k != int'(m_d2)) t2 = k;
         a = (m_p1 > int'(m_d1)); b = (m_p1 < int'(m_d1));
         c = (m_p2 > t2);         d = (m_p2 < t2);
         cycle(1'b0, a, b, c, d);
         n++;
      end
      chk("reach_reveal", 32'(n < 200), 32'd1);
      chk("p1_lives", 32'(p1_lives), 32'(LIVES));
      chk("p2_lives", 32'(p2_lives), 32'(exp_p2_lives));
      chk("sec_at_reveal", 32'(seconds_left), 32'd0);
      if (count_reveal) begin
         cnt = 0; n = 0;
         while (!resume && n < 100) begin
            if (time_up) cnt++;
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
         end
         chk("reveal_len", 32'(cnt), 32'(REVEAL * CLK_HZ));
      end
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      start = 1'b0; p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
      model_reset();

      // reset held, then released; idle ignores moves
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_vals", dut_vec(), RESET_VEC);
      reset_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("idle_quiet", dut_vec(), RESET_VEC);

      // start timed so the PICK cycle sees lfsr[3:0]=1111 (door 2 wraps to 0)
      n = 0;
      while ((lfsr_next(m_lfsr) & 8'h0F) != 8'h0F && n < 300) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      chk("find_wrap", 32'(n < 300), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("door1_wrap", 32'(correct_door_1), 32'd3);
      chk("door2_wrap", 32'(correct_door_2), 32'd0);
      chk("resume_pulse", 32'(resume), 32'd1);

      // five right pulses saturate at 3 (extra start ignored); l+r holds
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("p1_sat_right", 32'(player_1_pos), 32'd3);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("p1_lr_hold", 32'(player_1_pos), 32'd3);

      // three rounds with P2 always wrong -> game over, P1 wins
      play_round(LIVES - 1, 1'b1);
      play_round(LIVES - 2, 1'b1);
      play_round(LIVES - 3, 1'b0);
      repeat (25) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("game_over", 32'(game_over), 32'd1);
      chk("winner_p1", 32'(winner), 32'b01);
      chk("time_up_over", 32'(time_up), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_lives", {30'b0, p1_lives}, 32'(LIVES));
      chk("restart_lives2", {30'b0, p2_lives}, 32'(LIVES));
      chk("restart_winner", 32'(winner), 32'd0);

      // async reset in the middle of play
      n = 0;
      while (!(m_ph == PH_PLAY && m_sec == 4'd2) && n < 200) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         n++;
      end
      chk("reach_sec2", 32'(n < 200), 32'd1);
      reset_n = 1'b0;
      #1 chk("async_reset", dut_vec(), RESET_VEC);
      model_reset();
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // randomized play against the model
      for (int i = 0; i < 4000; i++)
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
